// File: rtl/kianv_pkg.sv
// ============================================================================
// Module      : kianv_pkg
// Description : Shared constants for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kianv_pkg;

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

endpackage : kianv_pkg

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// Module      : regfile_read_port
// Description : One combinational read port. When REGFILE_BYPASS_EN is defined,
//               a same-cycle write to the addressed entry is forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port #(
    parameter int REGISTER_DEPTH = 32,
    parameter int REGISTER_WIDTH = 32,
    parameter int AW             = 5
) (
    input  logic [REGISTER_DEPTH-1:0][REGISTER_WIDTH-1:0] i_mem,
    input  logic                                          i_idle,
    input  logic [AW-1:0]                                 i_addr,
    input  logic                                          i_wr_en,
    input  logic [AW-1:0]                                 i_wr_addr,
    input  logic [REGISTER_WIDTH-1:0]                     i_wr_data,
    output logic [REGISTER_WIDTH-1:0]                     o_data
);

    logic w_hit;

`ifdef REGFILE_BYPASS_EN
    assign w_hit = i_wr_en && (i_wr_addr == i_addr);
`else
    logic w_unused_bypass;
    assign w_unused_bypass = &{1'b0, i_wr_en, i_wr_addr, i_wr_data};
    assign w_hit           = 1'b0;
`endif

    // Entry 0 and the whole file during a clear sweep read as zero.
    always_comb begin
        o_data = '0;
        if (i_idle && (i_addr != '0)) begin
            if (w_hit) begin
`ifdef REGFILE_BYPASS_EN
                o_data = i_wr_data;
`endif
            end else begin
                o_data = i_mem[i_addr];
            end
        end
    end

endmodule : regfile_read_port

`default_nettype wire

// File: rtl/register_file_mp.sv
// ============================================================================
// Module      : register_file_mp
// Description : Multi-read-port register file with a sequential clear sweep.
//               Optional macro REGFILE_BYPASS_EN enables write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_mp
    import kianv_pkg::*;
#(
    parameter int REGISTER_DEPTH = 32,
    parameter int REGISTER_WIDTH = 32,
    parameter int READ_PORTS     = 2
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 we,
    input  logic [$clog2(REGISTER_DEPTH)-1:0]    A3,
    input  logic [REGISTER_WIDTH-1:0]            wd,
    input  logic [READ_PORTS*$clog2(REGISTER_DEPTH)-1:0] ra,
    output logic [READ_PORTS*REGISTER_WIDTH-1:0] rd,
    input  logic                                 clr_req,
    output logic                                 ready
);

    localparam int            AW     = $clog2(REGISTER_DEPTH);
    localparam logic [AW-1:0] c_ONE  = AW'(1);
    localparam logic [AW-1:0] c_LAST = AW'(REGISTER_DEPTH - 1);

    logic [0:0]                                   r_state;
    logic [0:0]                                   w_state_nxt;
    logic [AW-1:0]                                r_clr_cnt;
    logic [AW-1:0]                                w_cnt_nxt;
    logic [REGISTER_DEPTH-1:0][REGISTER_WIDTH-1:0] r_mem;

    logic                      w_idle;
    logic                      w_wr_en;
    logic                      w_mem_we;
    logic [AW-1:0]             w_mem_addr;
    logic [REGISTER_WIDTH-1:0] w_mem_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_ST_CLEAR;
            r_clr_cnt <= c_ONE;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_clr_cnt;
        if (r_state == c_ST_CLEAR) begin
            if (r_clr_cnt == c_LAST) begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = c_ONE;
            end else begin
                w_cnt_nxt   = r_clr_cnt + c_ONE;
            end
        end else if (clr_req) begin
            w_state_nxt = c_ST_CLEAR;
            w_cnt_nxt   = c_ONE;
        end
    end

    // A clear request takes priority over a coincident write.
    always_comb begin
        w_idle     = (r_state == c_ST_IDLE);
        ready      = w_idle;
        w_wr_en    = w_idle && we && (A3 != '0) && !clr_req;
        w_mem_we   = w_wr_en;
        w_mem_addr = A3;
        w_mem_data = wd;
        if (!w_idle) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr_cnt;
            w_mem_data = '0;
        end
    end

    // Storage is deliberately left out of reset; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd_port
        regfile_read_port #(
            .REGISTER_DEPTH (REGISTER_DEPTH),
            .REGISTER_WIDTH (REGISTER_WIDTH),
            .AW             (AW)
        ) u_rd_port (
            .i_mem     (r_mem),
            .i_idle    (w_idle),
            .i_addr    (ra[g*AW +: AW]),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (A3),
            .i_wr_data (wd),
            .o_data    (rd[g*REGISTER_WIDTH +: REGISTER_WIDTH])
        );
    end

endmodule : register_file_mp

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// ============================================================================
// Module      : tb_register_file_mp
// Description : Self-checking bench for register_file_mp (depth 32 and 64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default depth 32, two read ports
    logic        we_a = 0, clr_a = 0, ready_a;
    logic [4:0]  a3_a = 0;
    logic [31:0] wd_a = 0;
    logic [9:0]  ra_a = 0;
    logic [63:0] rd_a;
    // DUT B: depth 64, two read ports
    logic        we_b = 0, clr_b = 0, ready_b;
    logic [5:0]  a3_b = 0;
    logic [31:0] wd_b = 0;
    logic [11:0] ra_b = 0;
    logic [63:0] rd_b;

    register_file_mp u_dut_a (
        .clk(clk), .resetn(resetn), .we(we_a), .A3(a3_a), .wd(wd_a),
        .ra(ra_a), .rd(rd_a), .clr_req(clr_a), .ready(ready_a)
    );

    register_file_mp #(.REGISTER_DEPTH(64)) u_dut_b (
        .clk(clk), .resetn(resetn), .we(we_b), .A3(a3_b), .wd(wd_b),
        .ra(ra_b), .rd(rd_b), .clr_req(clr_b), .ready(ready_b)
    );

    // Reference model: contents plus "busy for N more edges" clear status
    logic [31:0] m_a [32];
    logic [31:0] m_b [64];
    bit idle_a = 0, idle_b = 0;
    int rem_a = 31, rem_b = 63;
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_a(input int addr);
        if (!idle_a || addr == 0) return 32'h0;
        if (BYP && we_a && !clr_a && a3_a != 0 && int'(a3_a) == addr) return wd_a;
        return m_a[addr];
    endfunction

    function automatic logic [31:0] exp_b(input int addr);
        if (!idle_b || addr == 0) return 32'h0;
        if (BYP && we_b && !clr_b && a3_b != 0 && int'(a3_b) == addr) return wd_b;
        return m_b[addr];
    endfunction

    task automatic model_edge();
        if (!resetn) begin
            idle_a = 0; rem_a = 31; idle_b = 0; rem_b = 63;
        end else begin
            if (!idle_a) begin
                rem_a--;
                if (rem_a == 0) begin
                    idle_a = 1;
                    for (int i = 0; i < 32; i++) m_a[i] = 32'h0;
                end
            end else if (clr_a) begin
                idle_a = 0; rem_a = 31;
            end else if (we_a && a3_a != 0) begin
                m_a[a3_a] = wd_a;
            end
            if (!idle_b) begin
                rem_b--;
                if (rem_b == 0) begin
                    idle_b = 1;
                    for (int i = 0; i < 64; i++) m_b[i] = 32'h0;
                end
            end else if (clr_b) begin
                idle_b = 0; rem_b = 63;
            end else if (we_b && a3_b != 0) begin
                m_b[a3_b] = wd_b;
            end
        end
    endtask

    // Check every output against the model, then advance one clock.
    task automatic tick();
        #1;
        if (!resetn) begin
            idle_a = 0; rem_a = 31; idle_b = 0; rem_b = 63;
        end
        check("ready_a", {63'h0, ready_a}, {63'h0, idle_a});
        check("rd_a0", {32'h0, rd_a[31:0]},  {32'h0, exp_a(int'(ra_a[4:0]))});
        check("rd_a1", {32'h0, rd_a[63:32]}, {32'h0, exp_a(int'(ra_a[9:5]))});
        check("ready_b", {63'h0, ready_b}, {63'h0, idle_b});
        check("rd_b0", {32'h0, rd_b[31:0]},  {32'h0, exp_b(int'(ra_b[5:0]))});
        check("rd_b1", {32'h0, rd_b[63:32]}, {32'h0, exp_b(int'(ra_b[11:6]))});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic count_busy_a(input string tag);
        int n = 0;
        while (!ready_a && n < 100) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'd31);
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        repeat (3) tick();
        resetn = 1'b1;
        count_busy_a("rst_ready_latency");

        // Every address reads zero after the first sweep
        for (int i = 0; i < 32; i++) begin
            ra_a = {5'(31 - i), 5'(i)};
            tick();
        end
        begin
            int n = 0;
            while (!ready_b && n < 100) begin tick(); n++; end
            check("ready_b_up", {63'h0, ready_b}, 64'h1);
        end

        // Dual-port read of the same entry
        we_a = 1; a3_a = 5'd17; wd_a = 32'hDEADBEEF;
        tick();
        we_a = 0; ra_a = {5'd17, 5'd17};
        #1;
        check("rd17_p0", {32'h0, rd_a[31:0]},  64'hDEADBEEF);
        check("rd17_p1", {32'h0, rd_a[63:32]}, 64'hDEADBEEF);
        tick();

        // Entry 0 is hardwired
        we_a = 1; a3_a = 5'd0; wd_a = 32'hFFFF_FFFF;
        tick();
        we_a = 0; ra_a = 10'd0;
        #1;
        check("rd0_zero", {32'h0, rd_a[31:0]}, 64'h0);
        tick();

        // Full 6-bit decode on the depth-64 instance
        we_b = 1; a3_b = 6'd5;  wd_b = 32'h1; tick();
        a3_b = 6'd21; wd_b = 32'h2; tick();
        a3_b = 6'd37; wd_b = 32'h3; tick();
        we_b = 0; ra_b = {6'd21, 6'd5};
        #1;
        check("b_rd5",  {32'h0, rd_b[31:0]},  64'h1);
        check("b_rd21", {32'h0, rd_b[63:32]}, 64'h2);
        tick();
        ra_b = {6'd37, 6'd5};
        #1;
        check("b_rd5_noalias", {32'h0, rd_b[31:0]},  64'h1);
        check("b_rd37",        {32'h0, rd_b[63:32]}, 64'h3);
        tick();

        // Same-cycle write/read collision
        we_a = 1; a3_a = 5'd9; wd_a = 32'h11; tick();
        wd_a = 32'h55; ra_a = {5'd0, 5'd9};
        #1;
        check("collide_rd9", {32'h0, rd_a[31:0]}, BYP ? 64'h55 : 64'h11);
        tick();
        we_a = 0;
        #1;
        check("after_rd9", {32'h0, rd_a[31:0]}, 64'h55);
        tick();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            we_a  = 1'($urandom);  a3_a = 5'($urandom);  wd_a = $urandom;
            ra_a  = 10'($urandom); clr_a = ($urandom_range(0, 63) == 0);
            we_b  = 1'($urandom);  a3_b = 6'($urandom);  wd_b = $urandom;
            ra_b  = 12'($urandom); clr_b = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) begin
                ra_a[4:0] = a3_a;
                ra_b[5:0] = a3_b;
            end
            tick();
        end
        we_a = 0; clr_a = 0; we_b = 0; clr_b = 0;
        begin
            int n = 0;
            while ((!ready_a || !ready_b) && n < 100) begin tick(); n++; end
            check("settle_ready", {62'h0, ready_a, ready_b}, 64'h3);
        end

        // Clear request wins over a coincident write
        we_a = 1; a3_a = 5'd3; wd_a = 32'hA5A5; tick();
        clr_a = 1; wd_a = 32'h1234; tick();
        clr_a = 0; we_a = 0; ra_a = {5'd3, 5'd3};
        count_busy_a("clr_ready_latency");
        #1;
        check("clr_rd3", {32'h0, rd_a[31:0]}, 64'h0);
        tick();

        // Reset asserted part-way through a sweep restarts it
        resetn = 0; tick();
        resetn = 1;
        repeat (10) tick();
        resetn = 0; tick();
        resetn = 1;
        count_busy_a("midsweep_rst_latency");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_register_file_mp

`default_nettype wire
